snow64_param_operand_manager: RTL and testbench
===============================================

SNOW64_PARAM_OPERAND_MANAGER -- requirements
Module: snow64_param_operand_manager

Interface
REQ-001 SHALL have parameter NUM_OPERANDS, default 3, meaning operand slots gathered per instruction.
REQ-002 SHALL have parameter VEC_WIDTH, default 256, meaning LAR data bits per operand.
REQ-003 SHALL have parameter SCALAR_WIDTH, default 64, meaning extended scalar output bits.
REQ-004 SHALL have parameter TAG_WIDTH, default 3, meaning LAR tag bits.
REQ-005 SHALL have parameter SB_DEPTH, default 4, meaning scoreboard entries for in-flight result tags.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset (one clock; reset is synchronous and active-high).
REQ-007 SHALL have ports: in_start in 1, begin gather; in_op_type in 1, 0=vector, 1=scalar.
REQ-008 SHALL have ports: in_tag in NUM_OPERANDS*TAG_WIDTH; in_offset in NUM_OPERANDS*log2(VEC_WIDTH/8), byte offset; in_data in NUM_OPERANDS*VEC_WIDTH; in_int_size in NUM_OPERANDS*2 (0=8b,1=16b,2=32b,3=64b); in_signed in NUM_OPERANDS.
REQ-009 SHALL have ports: in_issue_valid in 1, in_issue_tag in TAG_WIDTH, announcing a future write to a tag.
REQ-010 SHALL have ports: in_wb_valid in 1, in_wb_tag in TAG_WIDTH, in_wb_data in VEC_WIDTH, completed result.
REQ-011 SHALL have outputs: out_stall 1, out_valid 1, out_sb_full 1, out_vector_data NUM_OPERANDS*VEC_WIDTH, out_scalar_data NUM_OPERANDS*SCALAR_WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE, RESOLVE, WAIT, DONE.
REQ-013 IDLE: in_start=1 latches all operand inputs and in_op_type, goes to RESOLVE; in_start outside IDLE SHALL be ignored.
REQ-014 RESOLVE: per operand, mark pending if any valid scoreboard entry matches its tag and no same-cycle writeback to that tag; go to WAIT if any pending, else DONE.
REQ-015 WAIT: stay until every pending flag clears, then go to DONE.
REQ-016 In RESOLVE and WAIT, in_wb_valid with in_wb_tag equal to an operand's tag SHALL replace that operand's latched data with in_wb_data and clear its pending flag; multiple operands may match one writeback.
REQ-017 DONE: out_valid=1 for exactly one cycle, outputs stable, then IDLE.
REQ-018 out_stall SHALL be 1 in RESOLVE and WAIT, 0 otherwise.
REQ-019 Minimum latency: in_start at cycle N -> out_valid at cycle N+2.
REQ-020 Tag 0 is the zero register: never pending, its vector data forced to all zeros.
REQ-021 Scalar extraction: element index = offset >> in_int_size, byte-aligned down to element size; extracted element zero-extended (in_signed=0) or sign-extended (in_signed=1) to SCALAR_WIDTH.
REQ-022 out_scalar_data SHALL be all zeros when latched in_op_type=0.
REQ-023 Scoreboard: in_issue_valid allocates lowest-index free entry with in_issue_tag; issue to tag 0 ignored.
REQ-024 in_wb_valid SHALL invalidate all entries matching in_wb_tag, in every FSM state.
REQ-025 Simultaneous issue and writeback of the same tag: old entries cleared, new entry allocated (tag stays pending).
REQ-026 out_sb_full=1 when all SB_DEPTH entries valid; issue when full (and no same-cycle freeing writeback) SHALL be dropped.
REQ-027 Writeback matching no scoreboard entry and no pending operand SHALL have no effect.

Reset
REQ-028 rst=1 at clk edge: FSM to IDLE, all scoreboard entries invalid, pending flags cleared, out_valid=0, out_stall=0, out_sb_full=0, data outputs zero.
REQ-029 rst mid-gather (RESOLVE/WAIT) SHALL abort without asserting out_valid; rst overrides same-cycle in_start/issue/writeback.

Verification
REQ-030 No hazard: tags 1,2,3, empty scoreboard, in_start -> out_valid two cycles later, out_vector_data equals in_data.
REQ-031 Scalar: tag 1 data byte 5 = 0xF0, offset 5, size 0, signed=1, op_type=1 -> out_scalar_data slot0 = 0xFFFFFFFFFFFFFFF0; signed=0 -> 0xF0.
REQ-032 Hazard: issue tag 2, start with rb tag 2, writeback tag 2 data 0xAB.. after 3 cycles -> out_stall high 4 cycles, slot1 = writeback data.
REQ-033 Scoreboard full: 4 issues tags 1-4 -> out_sb_full=1, fifth issue tag 5 dropped, start on tag 5 -> no stall.
REQ-034 Tag 0 operand with issue tag 0 attempted -> no stall, vector slot all zeros.
REQ-035 Reset in WAIT -> next cycle IDLE, out_valid never asserted, out_sb_full=0.

Source files
------------

// File: rtl/snow64_param_operand_manager.sv
// Operand gather unit: latches the LAR operands of one instruction, waits out
// read-after-write hazards against a small tag scoreboard, then presents vector and scalar views.
module snow64_param_operand_manager #(
    parameter int NUM_OPERANDS = 3,
    parameter int VEC_WIDTH    = 256,
    parameter int SCALAR_WIDTH = 64,
    parameter int TAG_WIDTH    = 3,
    parameter int SB_DEPTH     = 4,
    localparam int OFF_WIDTH   = $clog2(VEC_WIDTH / 8)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_start,
    input  logic                                 in_op_type,
    input  logic [NUM_OPERANDS*TAG_WIDTH-1:0]    in_tag,
    input  logic [NUM_OPERANDS*OFF_WIDTH-1:0]    in_offset,
    input  logic [NUM_OPERANDS*VEC_WIDTH-1:0]    in_data,
    input  logic [NUM_OPERANDS*2-1:0]            in_int_size,
    input  logic [NUM_OPERANDS-1:0]              in_signed,
    input  logic                                 in_issue_valid,
    input  logic [TAG_WIDTH-1:0]                 in_issue_tag,
    input  logic                                 in_wb_valid,
    input  logic [TAG_WIDTH-1:0]                 in_wb_tag,
    input  logic [VEC_WIDTH-1:0]                 in_wb_data,
    output logic                                 out_stall,
    output logic                                 out_valid,
    output logic                                 out_sb_full,
    output logic [NUM_OPERANDS*VEC_WIDTH-1:0]    out_vector_data,
    output logic [NUM_OPERANDS*SCALAR_WIDTH-1:0] out_scalar_data
);

    typedef enum logic [1:0] {IDLE, RESOLVE, WAIT, DONE} state_t;

    state_t state_reg, state_next;

    logic [SB_DEPTH-1:0]  sb_valid_reg;
    logic [SB_DEPTH-1:0]  sb_kept;
    logic [SB_DEPTH-1:0]  sb_free;
    logic [SB_DEPTH-1:0]  sb_alloc;
    logic [TAG_WIDTH-1:0] sb_tag_reg [SB_DEPTH];
    logic                 issue_ok;

    logic [TAG_WIDTH-1:0] op_tag_reg  [NUM_OPERANDS];
    logic [OFF_WIDTH-1:0] op_off_reg  [NUM_OPERANDS];
    logic [1:0]           op_size_reg [NUM_OPERANDS];
    logic [VEC_WIDTH-1:0] op_data_reg [NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] op_signed_reg;
    logic                    op_type_reg;

    logic [NUM_OPERANDS-1:0] pending_reg, pending_next;
    logic [NUM_OPERANDS-1:0] sb_hit, wb_hit, resolve_pending;
    logic                    latch_en, capture_en;

    assign latch_en   = (state_reg == IDLE) && in_start;
    assign capture_en = (state_reg == RESOLVE) || (state_reg == WAIT);

    // Entries freed by a same-cycle writeback are reusable by a same-cycle issue.
    assign issue_ok = in_issue_valid && (in_issue_tag != '0);
    assign sb_free  = ~sb_kept & {SB_DEPTH{issue_ok}};
    assign sb_alloc = sb_free & (~sb_free + SB_DEPTH'(1));

    genvar gi;
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
            assign sb_kept[gi] = sb_valid_reg[gi] &&
                                 !(in_wb_valid && (sb_tag_reg[gi] == in_wb_tag));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_reg <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_tag_reg[i] <= '0;
            end
        end else begin
            sb_valid_reg <= sb_kept | sb_alloc;
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (sb_alloc[i]) begin
                    sb_tag_reg[i] <= in_issue_tag;
                end
            end
        end
    end

    assign out_sb_full = &sb_valid_reg;

    always_comb begin
        sb_hit = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            for (int j = 0; j < SB_DEPTH; j++) begin
                if (sb_valid_reg[j] && (sb_tag_reg[j] == op_tag_reg[i])) begin
                    sb_hit[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_op
            logic [OFF_WIDTH-1:0]    aligned_off;
            logic [63:0]             elem_raw;
            logic [SCALAR_WIDTH-1:0] elem_ext;

            // Tag 0 is the hard-wired zero register, so it never matches a writeback.
            assign wb_hit[gi] = in_wb_valid && (in_wb_tag == op_tag_reg[gi]) &&
                                (op_tag_reg[gi] != '0);
            assign resolve_pending[gi] = (op_tag_reg[gi] != '0) && sb_hit[gi] && !wb_hit[gi];

            assign aligned_off = (op_off_reg[gi] >> op_size_reg[gi]) << op_size_reg[gi];
            assign elem_raw    = 64'(op_data_reg[gi] >> {aligned_off, 3'b000});

            always_comb begin
                elem_ext = '0;
                case (op_size_reg[gi])
                    2'd0: begin
                        elem_ext      = {SCALAR_WIDTH{op_signed_reg[gi] & elem_raw[7]}};
                        elem_ext[7:0] = elem_raw[7:0];
                    end
                    2'd1: begin
                        elem_ext       = {SCALAR_WIDTH{op_signed_reg[gi] & elem_raw[15]}};
                        elem_ext[15:0] = elem_raw[15:0];
                    end
                    2'd2: begin
                        elem_ext       = {SCALAR_WIDTH{op_signed_reg[gi] & elem_raw[31]}};
                        elem_ext[31:0] = elem_raw[31:0];
                    end
                    default: begin
                        elem_ext       = {SCALAR_WIDTH{op_signed_reg[gi] & elem_raw[63]}};
                        elem_ext[63:0] = elem_raw;
                    end
                endcase
            end

            assign out_vector_data[gi*VEC_WIDTH +: VEC_WIDTH] = op_data_reg[gi];
            assign out_scalar_data[gi*SCALAR_WIDTH +: SCALAR_WIDTH] =
                op_type_reg ? elem_ext : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            op_type_reg   <= 1'b0;
            op_signed_reg <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                op_tag_reg[i]  <= '0;
                op_off_reg[i]  <= '0;
                op_size_reg[i] <= '0;
                op_data_reg[i] <= '0;
            end
        end else if (latch_en) begin
            op_type_reg   <= in_op_type;
            op_signed_reg <= in_signed;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                op_tag_reg[i]  <= in_tag[i*TAG_WIDTH +: TAG_WIDTH];
                op_off_reg[i]  <= in_offset[i*OFF_WIDTH +: OFF_WIDTH];
                op_size_reg[i] <= in_int_size[i*2 +: 2];
                op_data_reg[i] <= (in_tag[i*TAG_WIDTH +: TAG_WIDTH] == '0) ?
                                  '0 : in_data[i*VEC_WIDTH +: VEC_WIDTH];
            end
        end else if (capture_en) begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (wb_hit[i]) begin
                    op_data_reg[i] <= in_wb_data;
                end
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (in_start) begin
                    state_next   = RESOLVE;
                    pending_next = '0;
                end
            end
            RESOLVE: begin
                pending_next = resolve_pending;
                state_next   = (|resolve_pending) ? WAIT : DONE;
            end
            WAIT: begin
                pending_next = pending_reg & ~wb_hit;
                if (pending_next == '0) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    assign out_stall = (state_reg == RESOLVE) || (state_reg == WAIT);
    assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_snow64_param_operand_manager.sv
// Randomised bench for the operand gather unit: driver pushes expected gathers
// into a queue, a negedge monitor pops and compares when out_valid appears.
`timescale 1ns/1ps
module tb_snow64_param_operand_manager;

    localparam int N      = 3;
    localparam int VW     = 256;
    localparam int SW     = 64;
    localparam int TW     = 3;
    localparam int SBD    = 4;
    localparam int OW     = 5;
    localparam int TAGS_W = N * TW;
    localparam int DATA_W = N * VW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_start = 1'b0;
    logic              in_op_type = 1'b0;
    logic [N*TW-1:0]   in_tag = '0;
    logic [N*OW-1:0]   in_offset = '0;
    logic [N*VW-1:0]   in_data = '0;
    logic [N*2-1:0]    in_int_size = '0;
    logic [N-1:0]      in_signed = '0;
    logic              in_issue_valid = 1'b0;
    logic [TW-1:0]     in_issue_tag = '0;
    logic              in_wb_valid = 1'b0;
    logic [TW-1:0]     in_wb_tag = '0;
    logic [VW-1:0]     in_wb_data = '0;
    logic              out_stall, out_valid, out_sb_full;
    logic [N*VW-1:0]   out_vector_data;
    logic [N*SW-1:0]   out_scalar_data;

    snow64_param_operand_manager dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_op_type(in_op_type),
        .in_tag(in_tag), .in_offset(in_offset), .in_data(in_data),
        .in_int_size(in_int_size), .in_signed(in_signed),
        .in_issue_valid(in_issue_valid), .in_issue_tag(in_issue_tag),
        .in_wb_valid(in_wb_valid), .in_wb_tag(in_wb_tag), .in_wb_data(in_wb_data),
        .out_stall(out_stall), .out_valid(out_valid), .out_sb_full(out_sb_full),
        .out_vector_data(out_vector_data), .out_scalar_data(out_scalar_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*VW-1:0] vec;
        logic [N*SW-1:0] scal;
        int              stall;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] sb_q[$];
    int            tests = 0;
    int            fails = 0;
    int            stall_cnt = 0;
    exp_t          mon_e;

    logic [TW-1:0] g_tag  [N];
    logic [OW-1:0] g_off  [N];
    logic [VW-1:0] g_data [N];
    logic [1:0]    g_size [N];
    logic          g_sgn  [N];
    logic          g_op;
    logic [N*VW-1:0] last_vec;
    logic [N*SW-1:0] last_scal;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic logic [VW-1:0] rand256();
        logic [VW-1:0] v;
        for (int k = 0; k < VW / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit sb_has(input logic [TW-1:0] t);
        foreach (sb_q[k]) if (sb_q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Element = aligned group of 2^size bytes containing the offset, then extended.
    function automatic logic [SW-1:0] scal_model(input logic [VW-1:0] d, input logic [OW-1:0] off,
                                                 input logic [1:0] sz, input logic sg);
        int nb;
        int base;
        logic [SW-1:0] v;
        nb   = 1 << sz;
        base = (int'(off) / nb) * nb;
        v    = '0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = d[8*(base+b) +: 8];
        if (sg && nb < 8 && v[8*nb-1]) begin
            for (int k = 8*nb; k < SW; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_wb_valid) begin
                for (int k = sb_q.size() - 1; k >= 0; k--) begin
                    if (sb_q[k] == in_wb_tag) sb_q.delete(k);
                end
            end
            if (in_issue_valid && in_issue_tag != '0 && sb_q.size() < SBD)
                sb_q.push_back(in_issue_tag);
        end
        #1;
        in_start       = 1'b0;
        in_issue_valid = 1'b0;
        in_wb_valid    = 1'b0;
        check("sb_full", 256'(out_sb_full), 256'(sb_q.size() == SBD));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic drive_ops();
        for (int k = 0; k < N; k++) begin
            in_tag[k*TW +: TW]      = g_tag[k];
            in_offset[k*OW +: OW]   = g_off[k];
            in_data[k*VW +: VW]     = g_data[k];
            in_int_size[k*2 +: 2]   = g_size[k];
            in_signed[k]            = g_sgn[k];
        end
        in_op_type = g_op;
    endtask

    task automatic random_ops();
        for (int k = 0; k < N; k++) begin
            if (sb_q.size() != 0 && $urandom_range(0, 1) == 1)
                g_tag[k] = sb_q[$urandom_range(0, sb_q.size() - 1)];
            else
                g_tag[k] = TW'($urandom_range(0, 7));
            g_off[k]  = OW'($urandom_range(0, 31));
            g_size[k] = 2'($urandom_range(0, 3));
            g_sgn[k]  = 1'($urandom_range(0, 1));
            g_data[k] = rand256();
        end
        g_op = 1'($urandom_range(0, 1));
    endtask

    // mode 0: no writebacks; mode 1: one writeback of ftag at gather cycle fcycle;
    // mode 2: random writebacks, issues and ignored in_start pulses.
    task automatic gather(input int mode, input logic [TW-1:0] ftag, input int fcycle,
                          input logic [VW-1:0] fdata);
        logic [VW-1:0] mdata [N];
        bit            pend  [N];
        int            stall;
        bit            any;
        bit            do_wb;
        logic [TW-1:0] wt;
        logic [VW-1:0] wd;
        exp_t          e;
        drive_ops();
        in_start = 1'b1;
        if (mode == 2) begin
            if ($urandom_range(0, 3) == 0) begin
                in_issue_valid = 1'b1;
                in_issue_tag   = TW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) begin
                in_wb_valid = 1'b1;
                in_wb_tag   = TW'($urandom_range(0, 7));
                in_wb_data  = rand256();
            end
        end
        for (int k = 0; k < N; k++) mdata[k] = (g_tag[k] == '0) ? '0 : g_data[k];
        cyc();
        for (int k = 0; k < N; k++) pend[k] = (g_tag[k] != '0) && sb_has(g_tag[k]);
        stall = 0;
        do begin
            do_wb = 1'b0;
            wt    = '0;
            wd    = rand256();
            if (mode == 1) begin
                if (stall == fcycle) begin
                    do_wb = 1'b1;
                    wt    = ftag;
                    wd    = fdata;
                end
            end else if (mode == 2) begin
                if ($urandom_range(0, 1) == 1 || stall >= 6) begin
                    do_wb = 1'b1;
                    wt    = TW'($urandom_range(0, 7));
                    for (int k = 0; k < N; k++)
                        if (pend[k] && ($urandom_range(0, 1) == 1 || stall >= 6)) wt = g_tag[k];
                end
                if ($urandom_range(0, 2) == 0) begin
                    in_issue_valid = 1'b1;
                    in_issue_tag   = TW'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 2) == 0) begin
                    in_start   = 1'b1;
                    in_op_type = 1'($urandom_range(0, 1));
                    in_tag     = TAGS_W'($urandom);
                    for (int k = 0; k < N; k++) in_data[k*VW +: VW] = rand256();
                end
            end
            if (do_wb) begin
                in_wb_valid = 1'b1;
                in_wb_tag   = wt;
                in_wb_data  = wd;
                for (int k = 0; k < N; k++) begin
                    if (wt != '0 && g_tag[k] == wt) begin
                        mdata[k] = wd;
                        pend[k]  = 1'b0;
                    end
                end
            end
            stall++;
            cyc();
            any = 1'b0;
            for (int k = 0; k < N; k++) any |= pend[k];
        end while (any && stall < 40);
        last_vec  = out_vector_data;
        last_scal = out_scalar_data;
        for (int k = 0; k < N; k++) begin
            e.vec[k*VW +: VW]  = mdata[k];
            e.scal[k*SW +: SW] = g_op ? scal_model(mdata[k], g_off[k], g_size[k], g_sgn[k]) : '0;
        end
        e.stall = stall;
        exp_q.push_back(e);
        if (mode == 2 && $urandom_range(0, 1) == 1) begin
            in_start = 1'b1;
            in_tag   = TAGS_W'($urandom);
        end
        cyc();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            cyc();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected responses never appeared", exp_q.size());
            exp_q.delete();
            do_reset();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else begin
            if (out_stall) stall_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got out_valid=1, want no response");
                end else begin
                    mon_e = exp_q.pop_front();
                    for (int k = 0; k < N; k++) begin
                        check($sformatf("vec%0d", k), out_vector_data[k*VW +: VW], mon_e.vec[k*VW +: VW]);
                        check($sformatf("scal%0d", k), 256'(out_scalar_data[k*SW +: SW]),
                              256'(mon_e.scal[k*SW +: SW]));
                    end
                    check("stall_cycles", 256'(stall_cnt), 256'(mon_e.stall));
                    check("valid_without_stall", 256'(out_stall), 256'(0));
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            g_tag[k] = '0; g_off[k] = '0; g_data[k] = '0; g_size[k] = '0; g_sgn[k] = 1'b0;
        end
        g_op = 1'b0;
        do_reset();

        check("reset_valid", 256'(out_valid), 256'(0));
        check("reset_stall", 256'(out_stall), 256'(0));
        check("reset_sb_full", 256'(out_sb_full), 256'(0));
        check("reset_vec", 256'(|out_vector_data), 256'(0));
        check("reset_scal", 256'(|out_scalar_data), 256'(0));

        // No hazard: data passes through with minimum latency.
        for (int k = 0; k < N; k++) begin
            g_tag[k] = TW'(k + 1); g_data[k] = rand256();
        end
        g_op = 1'b0;
        gather(0, '0, 0, '0);
        drain();
        for (int k = 0; k < N; k++)
            check($sformatf("nohazard_vec%0d", k), last_vec[k*VW +: VW], g_data[k]);

        // Scalar byte extraction, signed and unsigned.
        g_data[0] = '0;
        g_data[0][47:40] = 8'hF0;
        g_off[0] = 5'd5; g_size[0] = 2'd0; g_sgn[0] = 1'b1; g_op = 1'b1;
        gather(0, '0, 0, '0);
        drain();
        check("scalar_signed", 256'(last_scal[63:0]), 256'(64'hFFFF_FFFF_FFFF_FFF0));
        g_sgn[0] = 1'b0;
        gather(0, '0, 0, '0);
        drain();
        check("scalar_unsigned", 256'(last_scal[63:0]), 256'(64'hF0));

        // Hazard on tag 2 resolved by a writeback on the fourth stall cycle.
        in_issue_valid = 1'b1; in_issue_tag = 3'd2;
        cyc();
        g_op = 1'b0;
        gather(1, 3'd2, 3, {32{8'hAB}});
        drain();
        check("hazard_slot1", last_vec[VW +: VW], {32{8'hAB}});

        // Full scoreboard drops the fifth issue.
        for (int t = 1; t <= 4; t++) begin
            in_issue_valid = 1'b1; in_issue_tag = TW'(t);
            cyc();
        end
        check("sb_full_after_4", 256'(out_sb_full), 256'(1));
        in_issue_valid = 1'b1; in_issue_tag = 3'd5;
        cyc();
        for (int k = 0; k < N; k++) g_tag[k] = 3'd5;
        gather(0, '0, 0, '0);
        drain();
        do_reset();

        // Zero register: issue to tag 0 ignored, data forced to zero.
        in_issue_valid = 1'b1; in_issue_tag = 3'd0;
        cyc();
        g_tag[0] = 3'd0; g_tag[1] = 3'd1; g_tag[2] = 3'd2;
        for (int k = 0; k < N; k++) g_data[k] = rand256();
        gather(0, '0, 0, '0);
        drain();
        check("tag0_zero", last_vec[0 +: VW], 256'(0));

        // Reset while waiting aborts the gather and clears the scoreboard.
        in_issue_valid = 1'b1; in_issue_tag = 3'd3;
        cyc();
        g_tag[0] = 3'd3;
        drive_ops();
        in_start = 1'b1;
        cyc();
        cyc();
        check("wait_stall", 256'(out_stall), 256'(1));
        rst = 1'b1; in_start = 1'b1; in_issue_valid = 1'b1; in_issue_tag = 3'd4;
        in_wb_valid = 1'b1; in_wb_tag = 3'd3;
        cyc();
        rst = 1'b0;
        check("abort_stall", 256'(out_stall), 256'(0));
        check("abort_valid", 256'(out_valid), 256'(0));
        check("abort_sb_full", 256'(out_sb_full), 256'(0));
        for (int i = 0; i < 5; i++) cyc();

        // Randomised gathers with background scoreboard traffic.
        for (int it = 0; it < 150; it++) begin
            int idle;
            idle = $urandom_range(0, 4);
            for (int i = 0; i < idle; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    in_issue_valid = 1'b1; in_issue_tag = TW'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 3) == 0) begin
                    in_wb_valid = 1'b1; in_wb_tag = TW'($urandom_range(0, 7)); in_wb_data = rand256();
                end
                cyc();
            end
            random_ops();
            gather(2, '0, 0, '0);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
